// File: rtl/dot_product_accumulator.sv
// ---------------------------------------------------------------------------
// dot_product_accumulator
//
// Sums a programmable number of unsigned products, one per handshake, into a
// saturating accumulator. The finished sum is then offered on a separate
// valid/ready result channel. It sits directly after the array multiplier and
// turns it into a dot-product / MAC datapath.
//
// Parameters
//   MUL_WIDTH  operand width of the upstream multiplier (product = 2*MUL_WIDTH)
//   ACC_WIDTH  accumulator / result width, must be >= 2*MUL_WIDTH
//   CNT_WIDTH  width of the term-count field
//
// Ports
//   clk_in         single clock, rising edge
//   rst_in         synchronous active-high reset
//   len_in         terms per dot product, sampled on the first accepted term
//                  (0 behaves as 1)
//   p_valid_in     product on p_in is valid
//   p_in           unsigned product
//   p_ready_out    product accepted when p_valid_in is also high
//   acc_valid_out  acc_out / ovf_out hold a finished result
//   acc_out        accumulated sum (saturated)
//   ovf_out        sum saturated somewhere in this dot product
//   acc_ready_in   downstream takes the result
//   busy_out       dot product in progress or result pending
// ---------------------------------------------------------------------------
module dot_product_accumulator #(
    parameter int MUL_WIDTH = 4,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [CNT_WIDTH-1:0]   len_in,
    input  logic                   p_valid_in,
    input  logic [2*MUL_WIDTH-1:0] p_in,
    output logic                   p_ready_out,
    output logic                   acc_valid_out,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   ovf_out,
    input  logic                   acc_ready_in,
    output logic                   busy_out
);

    localparam int P_WIDTH = 2 * MUL_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [ACC_WIDTH-1:0]   acc_reg,   acc_next;
    logic [CNT_WIDTH-1:0]   cnt_reg,   cnt_next;
    logic [CNT_WIDTH-1:0]   len_reg,   len_next;
    logic                   ovf_reg,   ovf_next;

    logic                   p_ready_int;
    logic                   acc_valid_int;
    logic [CNT_WIDTH-1:0]   len_eff;
    logic [ACC_WIDTH-1:0]   p_ext;
    logic [ACC_WIDTH:0]     sum_wide;   // one extra bit to expose the carry-out

    // A requested length of zero is folded to a single term.
    assign len_eff  = (len_in == '0) ? CNT_WIDTH'(1) : len_in;
    assign p_ext    = ACC_WIDTH'(p_in);
    assign sum_wide = {1'b0, acc_reg} + (ACC_WIDTH + 1)'(p_in);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            len_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
            ovf_reg   <= ovf_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state, datapath update and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        cnt_next      = cnt_reg;
        len_next      = len_reg;
        ovf_next      = ovf_reg;
        p_ready_int   = 1'b0;
        acc_valid_int = 1'b0;

        case (state_reg)
            IDLE: begin
                p_ready_int = 1'b1;
                if (p_valid_in) begin
                    // First term starts a fresh sum; it cannot overflow since
                    // the accumulator is at least as wide as a product.
                    len_next   = len_eff;
                    acc_next   = p_ext;
                    cnt_next   = CNT_WIDTH'(1);
                    ovf_next   = 1'b0;
                    state_next = (len_eff == CNT_WIDTH'(1)) ? HOLD : ACCUM;
                end
            end

            ACCUM: begin
                p_ready_int = 1'b1;
                if (p_valid_in) begin
                    cnt_next = cnt_reg + CNT_WIDTH'(1);
                    // Once saturated, the sum is pinned at all ones for the
                    // rest of this dot product.
                    if (ovf_reg || sum_wide[ACC_WIDTH]) begin
                        acc_next = '1;
                        ovf_next = 1'b1;
                    end else begin
                        acc_next = sum_wide[ACC_WIDTH-1:0];
                    end
                    if (cnt_reg == (len_reg - CNT_WIDTH'(1))) begin
                        state_next = HOLD;
                    end
                end
            end

            HOLD: begin
                acc_valid_int = 1'b1;
                if (acc_ready_in) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are forced quiet while reset is asserted so that a handshake
    // coinciding with reset is never seen as a transfer by either neighbour.
    assign p_ready_out   = p_ready_int & ~rst_in;
    assign acc_valid_out = acc_valid_int & ~rst_in;
    assign acc_out       = rst_in ? '0 : acc_reg;
    assign ovf_out       = ovf_reg & ~rst_in;
    assign busy_out      = (state_reg != IDLE) & ~rst_in;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_dot_product_accumulator
//
// Directed-vector bench for dot_product_accumulator with ACC_WIDTH=10 so that
// saturation is reachable with 4-bit operands. Inputs change 1 time unit
// after the rising edge; outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_dot_product_accumulator;

    localparam int MUL_WIDTH = 4;
    localparam int ACC_WIDTH = 10;
    localparam int CNT_WIDTH = 8;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic [CNT_WIDTH-1:0]   len_in;
    logic                   p_valid_in;
    logic [2*MUL_WIDTH-1:0] p_in;
    logic                   p_ready_out;
    logic                   acc_valid_out;
    logic [ACC_WIDTH-1:0]   acc_out;
    logic                   ovf_out;
    logic                   acc_ready_in;
    logic                   busy_out;

    int checks = 0;
    int errors = 0;

    dot_product_accumulator #(
        .MUL_WIDTH (MUL_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .len_in        (len_in),
        .p_valid_in    (p_valid_in),
        .p_in          (p_in),
        .p_ready_out   (p_ready_out),
        .acc_valid_out (acc_valid_out),
        .acc_out       (acc_out),
        .ovf_out       (ovf_out),
        .acc_ready_in  (acc_ready_in),
        .busy_out      (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Present one product for exactly one edge; the block must be ready.
    task automatic send_term(input logic [7:0] p);
        check("term_ready", p_ready_out, 1);
        p_valid_in = 1'b1;
        p_in       = p;
        tick();
        p_valid_in = 1'b0;
    endtask

    // Take the pending result; the block returns to IDLE.
    task automatic take_result();
        acc_ready_in = 1'b1;
        tick();
        acc_ready_in = 1'b0;
        check("after_take_valid", acc_valid_out, 0);
        check("after_take_busy", busy_out, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1 (simulation finished in time)");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in       = 1'b1;
        len_in       = '0;
        p_valid_in   = 1'b0;
        p_in         = '0;
        acc_ready_in = 1'b0;
        tick();
        tick();
        check("rst_p_ready", p_ready_out, 0);
        check("rst_acc_valid", acc_valid_out, 0);
        check("rst_acc_out", acc_out, 0);
        check("rst_ovf", ovf_out, 0);
        check("rst_busy", busy_out, 0);
        rst_in = 1'b0;
        tick();
        check("idle_p_ready", p_ready_out, 1);
        check("idle_busy", busy_out, 0);

        // Single term: 0x2D = 45
        len_in = 8'd1;
        send_term(8'h2D);
        check("single_valid", acc_valid_out, 1);
        check("single_acc", acc_out, 45);
        check("single_ovf", ovf_out, 0);
        check("single_p_ready", p_ready_out, 0);
        take_result();

        // Four terms with a two-cycle bubble: 6+12+0+225 = 243
        len_in = 8'd4;
        send_term(8'd6);
        check("four_busy_t1", busy_out, 1);
        send_term(8'd12);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("four_busy_bubble", busy_out, 1);
            check("four_valid_bubble", acc_valid_out, 0);
        end
        send_term(8'd0);
        check("four_valid_t3", acc_valid_out, 0);
        send_term(8'd225);
        check("four_valid", acc_valid_out, 1);
        check("four_acc", acc_out, 243);
        check("four_ovf", ovf_out, 0);
        check("four_busy_hold", busy_out, 1);

        // Backpressure: result held while upstream keeps offering 7.
        len_in     = 8'd1;
        p_in       = 8'd7;
        p_valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_acc", acc_out, 243);
            check("bp_valid", acc_valid_out, 1);
            check("bp_p_ready", p_ready_out, 0);
        end
        acc_ready_in = 1'b1;
        tick();
        acc_ready_in = 1'b0;
        check("bp_turn_valid", acc_valid_out, 0);
        check("bp_turn_p_ready", p_ready_out, 1);
        tick();
        p_valid_in = 1'b0;
        check("bp_next_valid", acc_valid_out, 1);
        check("bp_next_acc", acc_out, 7);
        take_result();

        // Saturation: 5 x 225 = 1125 > 1023
        len_in = 8'd5;
        for (int i = 0; i < 5; i++) send_term(8'd225);
        check("sat_valid", acc_valid_out, 1);
        check("sat_acc", acc_out, 1023);
        check("sat_ovf", ovf_out, 1);
        take_result();
        len_in = 8'd1;
        send_term(8'd3);
        check("post_sat_acc", acc_out, 3);
        check("post_sat_ovf", ovf_out, 0);
        take_result();

        // len_in = 0 behaves as one term
        len_in = 8'd0;
        send_term(8'd9);
        check("len0_valid", acc_valid_out, 1);
        check("len0_acc", acc_out, 9);
        take_result();

        // Length latched on the first term: 3 then 7 -> 1+2+4 = 7 after 3 terms
        len_in = 8'd3;
        send_term(8'd1);
        len_in = 8'd7;
        send_term(8'd2);
        check("len_chg_valid_t2", acc_valid_out, 0);
        send_term(8'd4);
        check("len_chg_valid", acc_valid_out, 1);
        check("len_chg_acc", acc_out, 7);
        take_result();

        // Reset after 2 of 4 terms discards the partial sum.
        len_in = 8'd4;
        send_term(8'd5);
        send_term(8'd6);
        check("mid_busy", busy_out, 1);
        rst_in = 1'b1;
        #1;
        check("mid_rst_p_ready", p_ready_out, 0);
        check("mid_rst_acc", acc_out, 0);
        check("mid_rst_busy", busy_out, 0);
        tick();
        rst_in = 1'b0;
        #1;
        check("mid_post_p_ready", p_ready_out, 1);
        check("mid_post_busy", busy_out, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_post_valid", acc_valid_out, 0);
        end
        len_in = 8'd2;
        send_term(8'd1);
        send_term(8'd2);
        check("mid_next_valid", acc_valid_out, 1);
        check("mid_next_acc", acc_out, 3);
        take_result();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
